// File: rtl/audio_nios_cpu_mulx_pkg.sv
// Shared definitions for the extended-multiply sequencer.
// Holds the op encodings, the sequencer state type and the partial-product count.
package audio_nios_cpu_mulx_pkg;

  localparam logic [1:0] OP_MUL    = 2'b00;  // low 32 bits
  localparam logic [1:0] OP_MULXUU = 2'b01;  // high word, both unsigned
  localparam logic [1:0] OP_MULXSU = 2'b10;  // high word, src1 signed, src2 unsigned
  localparam logic [1:0] OP_MULXSS = 2'b11;  // high word, both signed

  localparam int NUM_PARTIALS = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    FLUSH = 3'd2,
    CORR  = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/audio_nios_cpu_mulx_pp16.sv
// Pipelined 16x16 unsigned multiplier with a valid bit and a 2-bit weight
// tag carried alongside each product.
// Ports: clk, reset (async, active-high); a, b operands; valid_in/shift_in
// tag inputs; product, valid_out, shift_out appear MUL_LATENCY cycles later.
module audio_nios_cpu_mulx_pp16 #(
  parameter int MUL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        valid_in,
  input  logic [1:0]  shift_in,
  output logic [31:0] product,
  output logic        valid_out,
  output logic [1:0]  shift_out
);

  logic [31:0] prod_q  [MUL_LATENCY];
  logic        valid_q [MUL_LATENCY];
  logic [1:0]  shift_q [MUL_LATENCY];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MUL_LATENCY; i++) begin
        prod_q[i]  <= '0;
        valid_q[i] <= 1'b0;
        shift_q[i] <= '0;
      end
    end else begin
      prod_q[0]  <= {16'b0, a} * {16'b0, b};
      valid_q[0] <= valid_in;
      shift_q[0] <= shift_in;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        prod_q[i]  <= prod_q[i-1];
        valid_q[i] <= valid_q[i-1];
        shift_q[i] <= shift_q[i-1];
      end
    end
  end

  assign product   = prod_q[MUL_LATENCY-1];
  assign valid_out = valid_q[MUL_LATENCY-1];
  assign shift_out = shift_q[MUL_LATENCY-1];

endmodule

// File: rtl/audio_nios_cpu_mulx_seq.sv
// Multi-cycle multiply sequencer for MUL / MULXUU / MULXSU / MULXSS.
// Issues four 16x16 partial products, accumulates a 64-bit unsigned product,
// then sign-corrects the high word.
// Ports: clk, reset (async, active-high); start, op, src1, src2 request;
// busy (state != IDLE), done (1-cycle pulse), result (held until next done).
//
//   state | meaning
//   IDLE  | waiting for start; operands latched on accept
//   ISSUE | four cycles driving partial products idx 0..3
//   FLUSH | MUL_LATENCY cycles draining the multiplier pipeline
//   CORR  | sign-correct the high word, register result
//   DONE  | done pulse, back to IDLE next edge
module audio_nios_cpu_mulx_seq
  import audio_nios_cpu_mulx_pkg::*;
#(
  parameter int MUL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  state_t      state;
  logic [1:0]  idx;
  logic [1:0]  flush_cnt;
  logic [31:0] a_q, b_q;
  logic [1:0]  op_q;
  logic [63:0] acc;

  logic [15:0] pp_a, pp_b;
  logic [1:0]  pp_shift;
  logic [31:0] pp_prod;
  logic        pp_valid;
  logic [1:0]  pp_shift_out;
  logic [63:0] pp_term;
  logic [31:0] corr;
  logic [31:0] hi;

  // idx bit0 selects the A half, bit1 the B half; weight is 0/16/16/32.
  always_comb begin
    pp_a     = idx[0] ? a_q[31:16] : a_q[15:0];
    pp_b     = idx[1] ? b_q[31:16] : b_q[15:0];
    pp_shift = {idx[1] & idx[0], idx[1] ^ idx[0]};
  end

  audio_nios_cpu_mulx_pp16 #(.MUL_LATENCY(MUL_LATENCY)) u_pp16 (
    .clk       (clk),
    .reset     (reset),
    .a         (pp_a),
    .b         (pp_b),
    .valid_in  (state == ISSUE),
    .shift_in  (pp_shift),
    .product   (pp_prod),
    .valid_out (pp_valid),
    .shift_out (pp_shift_out)
  );

  always_comb begin
    case (pp_shift_out)
      2'd0:    pp_term = {32'b0, pp_prod};
      2'd1:    pp_term = {16'b0, pp_prod, 16'b0};
      default: pp_term = {pp_prod, 32'b0};
    endcase
  end

  // Two's-complement fix-up: a negative operand contributed 2^32 * other
  // operand too much to the unsigned high word.
  always_comb begin
    corr = ((op_q[1] && a_q[31]) ? b_q : 32'b0)
         + (((op_q == OP_MULXSS) && b_q[31]) ? a_q : 32'b0);
    hi   = acc[63:32] - corr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      flush_cnt <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      acc       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
    end else begin
      if (pp_valid)
        acc <= acc + pp_term;

      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= src1;
            b_q   <= src2;
            op_q  <= op;
            acc   <= '0;
            idx   <= '0;
            busy  <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (idx == 2'(NUM_PARTIALS - 1)) begin
            flush_cnt <= 2'(MUL_LATENCY - 1);
            state     <= FLUSH;
          end else begin
            idx <= idx + 2'd1;
          end
        end
        FLUSH: begin
          if (flush_cnt == 2'd0)
            state <= CORR;
          else
            flush_cnt <= flush_cnt - 2'd1;
        end
        CORR: begin
          result <= (op_q == OP_MUL) ? acc[31:0] : hi;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_nios_cpu_mulx_seq.sv
module tb_audio_nios_cpu_mulx_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start1 = 1'b0, start3 = 1'b0;
  logic [1:0]  op1 = '0, op3 = '0;
  logic [31:0] a1 = '0, b1 = '0, a3 = '0, b3 = '0;
  logic        busy1, done1, busy3, done3;
  logic [31:0] result1, result3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  audio_nios_cpu_mulx_seq dut1 (
    .clk(clk), .reset(reset), .start(start1), .op(op1), .src1(a1), .src2(b1),
    .busy(busy1), .done(done1), .result(result1));

  audio_nios_cpu_mulx_seq #(.MUL_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .op(op3), .src1(a3), .src2(b3),
    .busy(busy3), .done(done3), .result(result3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one operation on the selected instance; optionally pokes start with
  // other operands one cycle into ISSUE, which must be ignored.
  task automatic run(input bit d3, input logic [1:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp,
                     input int exp_lat, input bit poke, input string tag);
    int n, dn, bz, lat;
    logic [31:0] res_at_done;
    n = 0; dn = 0; bz = 0; lat = -1; res_at_done = 'x;
    @(negedge clk);
    if (d3) begin start3 = 1; op3 = o; a3 = a; b3 = b; end
    else    begin start1 = 1; op1 = o; a1 = a; b1 = b; end
    @(posedge clk); #1;
    if (d3 ? busy3 : busy1) bz++;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      // operands scrambled after E0 must not affect the result
      if (d3) begin start3 = (poke && c == 1); op3 = ~o; a3 = 32'h1234_5678; b3 = 32'h0BAD_F00D; end
      else    begin start1 = (poke && c == 1); op1 = ~o; a1 = 32'h1234_5678; b1 = 32'h0BAD_F00D; end
      @(posedge clk); #1;
      n++;
      if (d3 ? busy3 : busy1) bz++;
      if (d3 ? done3 : done1) begin
        dn++;
        if (dn == 1) begin lat = n; res_at_done = d3 ? result3 : result1; end
      end
    end
    check({tag, "_result"}, res_at_done, exp);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_done_count"}, 32'(dn), 32'd1);
    check({tag, "_busy_cycles"}, 32'(bz), 32'(exp_lat + 1));
    check({tag, "_result_hold"}, d3 ? result3 : result1, exp);
  endtask

  initial begin
    #12;
    check("reset_busy", {31'b0, busy1}, 32'd0);
    check("reset_done", {31'b0, done1}, 32'd0);
    check("reset_result", result1, 32'd0);
    @(negedge clk); reset = 0;

    run(0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 6, 0, "xuu_ones");
    run(0, 2'b00, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 6, 0, "mul_10001");
    run(0, 2'b01, 32'h0001_0001, 32'h0001_0001, 32'h0000_0001, 6, 0, "xuu_10001");
    run(0, 2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 6, 0, "xss_m1x2");
    run(0, 2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 6, 0, "xss_min");
    run(0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 6, 0, "xsu_min");
    run(0, 2'b01, 32'hDEAD_BEEF, 32'h0000_0010, 32'h0000_000D, 6, 1, "poke_l1");
    run(1, 2'b01, 32'hDEAD_BEEF, 32'h0000_0010, 32'h0000_000D, 8, 1, "poke_l3");

    // reset during ISSUE idx2 aborts immediately
    @(negedge clk);
    start1 = 1; op1 = 2'b01; a1 = 32'hFFFF_FFFF; b1 = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    start1 = 0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1; #1;
    check("abort_busy", {31'b0, busy1}, 32'd0);
    check("abort_done", {31'b0, done1}, 32'd0);
    check("abort_result", result1, 32'd0);
    @(negedge clk); reset = 0;

    run(0, 2'b01, 32'd3, 32'd5, 32'h0000_0000, 6, 0, "post_xuu");
    run(0, 2'b00, 32'd3, 32'd5, 32'h0000_000F, 6, 0, "post_mul");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
